// File: rtl/icline_resp.sv
// icline_resp: memory-side responder for the I-cache line-fetch port.
// Fills a 16-byte line from a 32-bit word bus in four beats and keeps the
// last filled line in a one-entry buffer so repeated requests hit.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   memPcAddr/memPcOE   line request (tag = memPcAddr[31:4]), held until OK/FAULT
//   memPcData/memPcOK   128-bit line buffer and response status
//   extAddr/extOE       word-read request to the external arbiter
//   extData/extOK       returned word and word-bus status
// Status encoding: READY=00, OK=01, HOLD=10, FAULT=11.

module icline_resp #(
    parameter int TIMEOUT_W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [31:0]  memPcAddr,
    input  logic         memPcOE,
    output logic [127:0] memPcData,
    output logic [1:0]   memPcOK,
    output logic [31:0]  extAddr,
    output logic         extOE,
    input  logic [31:0]  extData,
    input  logic [1:0]   extOK
);

    localparam logic [1:0] ST_READY = 2'b00;
    localparam logic [1:0] ST_OK    = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;
    localparam logic [1:0] ST_FAULT = 2'b11;

    // A beat faults on the wait cycle that would bring the counter to all-ones.
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST =
        TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2,
        FLT  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [127:0]         lineBuf_q, lineBuf_d;
    logic [27:0]          lineTag_q, lineTag_d;
    logic                 lineValid_q, lineValid_d;
    logic [27:0]          reqTag_q, reqTag_d;
    logic [1:0]           beat_q, beat_d;
    logic [TIMEOUT_W-1:0] waitCnt_q, waitCnt_d;
    logic [1:0]           memPcOK_q, memPcOK_d;
    logic [31:0]          extAddr_q, extAddr_d;
    logic                 extOE_q, extOE_d;

    logic [27:0]          reqTagIn;
    logic                 tagHit;
    logic                 startFill;

    assign reqTagIn  = memPcAddr[31:4];
    assign tagHit    = lineValid_q && (reqTagIn == lineTag_q);

    assign memPcData = lineBuf_q;
    assign memPcOK   = memPcOK_q;
    assign extAddr   = extAddr_q;
    assign extOE     = extOE_q;

    always_comb begin
        state_d     = state_q;
        lineBuf_d   = lineBuf_q;
        lineTag_d   = lineTag_q;
        lineValid_d = lineValid_q;
        reqTag_d    = reqTag_q;
        beat_d      = beat_q;
        waitCnt_d   = waitCnt_q;
        startFill   = 1'b0;

        case (state_q)
            IDLE: begin
                if (memPcOE) begin
                    if (tagHit) begin
                        state_d = DONE;
                    end else begin
                        startFill = 1'b1;
                    end
                end
            end
            FILL: begin
                case (extOK)
                    ST_OK: begin
                        lineBuf_d[{beat_q, 5'b0} +: 32] = extData;
                        waitCnt_d = '0;
                        beat_d    = beat_q + 2'd1;
                        if (beat_q == 2'd3) begin
                            lineTag_d   = reqTag_q;
                            lineValid_d = 1'b1;
                            state_d     = memPcOE ? DONE : IDLE;
                        end
                    end
                    ST_FAULT: begin
                        state_d = FLT;
                    end
                    default: begin
                        if (waitCnt_q == WAIT_LAST) begin
                            state_d = FLT;
                        end else begin
                            waitCnt_d = waitCnt_q + 1'b1;
                        end
                    end
                endcase
            end
            DONE: begin
                if (!memPcOE) begin
                    state_d = IDLE;
                end else if (reqTagIn != lineTag_q) begin
                    startFill = 1'b1;
                end
            end
            FLT: begin
                if (!memPcOE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new miss discards the buffered line before any beat lands.
        if (startFill) begin
            state_d     = FILL;
            beat_d      = 2'd0;
            waitCnt_d   = '0;
            reqTag_d    = reqTagIn;
            lineValid_d = 1'b0;
        end
    end

    // Outputs are registered, so they are derived from the next state.
    always_comb begin
        memPcOK_d = ST_READY;
        extOE_d   = 1'b0;
        extAddr_d = 32'h0;
        case (state_d)
            IDLE: memPcOK_d = ST_READY;
            FILL: begin
                memPcOK_d = ST_HOLD;
                extOE_d   = 1'b1;
                extAddr_d = {reqTag_d, beat_d, 2'b00};
            end
            DONE:    memPcOK_d = ST_OK;
            FLT:     memPcOK_d = ST_FAULT;
            default: memPcOK_d = ST_READY;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            lineBuf_q   <= '0;
            lineTag_q   <= '0;
            lineValid_q <= 1'b0;
            reqTag_q    <= '0;
            beat_q      <= 2'd0;
            waitCnt_q   <= '0;
            memPcOK_q   <= ST_READY;
            extAddr_q   <= 32'h0;
            extOE_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lineBuf_q   <= lineBuf_d;
            lineTag_q   <= lineTag_d;
            lineValid_q <= lineValid_d;
            reqTag_q    <= reqTag_d;
            beat_q      <= beat_d;
            waitCnt_q   <= waitCnt_d;
            memPcOK_q   <= memPcOK_d;
            extAddr_q   <= extAddr_d;
            extOE_q     <= extOE_d;
        end
    end

endmodule

// File: tb/tb_icline_resp.sv
// tb_icline_resp: directed and randomized checks of icline_resp against a
// line-level reference model (word memory + one-entry tag/valid record).

module tb_icline_resp;

    localparam logic [1:0] READY = 2'b00;
    localparam logic [1:0] OK    = 2'b01;
    localparam logic [1:0] HOLD  = 2'b10;
    localparam logic [1:0] FAULT = 2'b11;

    logic         clk;
    logic         rst_n;
    logic [31:0]  memPcAddr;
    logic         memPcOE;
    logic [127:0] memPcData;
    logic [1:0]   memPcOK;
    logic [31:0]  extAddr;
    logic         extOE;
    logic [31:0]  extData;
    logic [1:0]   extOK;

    logic [31:0]  memPcAddr2;
    logic         memPcOE2;
    logic [127:0] memPcData2;
    logic [1:0]   memPcOK2;
    logic [31:0]  extAddr2;
    logic         extOE2;
    logic [31:0]  extData2;
    logic [1:0]   extOK2;

    int checks = 0;
    int errors = 0;

    // Reference model: word memory and the single retained line.
    logic [31:0] mem [logic [31:0]];
    logic        mvalid;
    logic [27:0] mtag;

    icline_resp dut (
        .clock     (clk),
        .reset     (rst_n),
        .memPcAddr (memPcAddr),
        .memPcOE   (memPcOE),
        .memPcData (memPcData),
        .memPcOK   (memPcOK),
        .extAddr   (extAddr),
        .extOE     (extOE),
        .extData   (extData),
        .extOK     (extOK)
    );

    icline_resp #(.TIMEOUT_W(2)) dut2 (
        .clock     (clk),
        .reset     (rst_n),
        .memPcAddr (memPcAddr2),
        .memPcOE   (memPcOE2),
        .memPcData (memPcData2),
        .memPcOK   (memPcOK2),
        .extAddr   (extAddr2),
        .extOE     (extOE2),
        .extData   (extData2),
        .extOK     (extOK2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    function automatic logic [127:0] line_of(input logic [27:0] t);
        return {word({t, 4'hC}), word({t, 4'h8}),
                word({t, 4'h4}), word({t, 4'h0})};
    endfunction

    // One request: fb = beat that faults (-1 none), beat wb gets wn waits,
    // other beats get 0..maxw random wait cycles.
    task automatic request(input logic [31:0] addr, input int fb,
                           input int wb, input int wn, input int maxw);
        logic [27:0] tag;
        logic [1:0]  bb;
        int          w;
        tag = addr[31:4];
        @(negedge clk);
        memPcOE   = 1'b1;
        memPcAddr = addr;
        extOK     = READY;
        @(negedge clk);
        if (mvalid && tag == mtag) begin
            chk("hit_ok", memPcOK, OK);
            chk("hit_extoe", extOE, 1'b0);
            chk("hit_data", memPcData, line_of(tag));
            return;
        end
        mvalid = 1'b0;
        chk("miss_hold", memPcOK, HOLD);
        for (int b = 0; b < 4; b++) begin
            bb = b[1:0];
            if (b == fb) w = 0;
            else if (b == wb) w = wn;
            else w = int'($urandom_range(0, maxw));
            for (int k = 0; k < w; k++) begin
                chk("wait_addr", extAddr, {tag, bb, 2'b00});
                chk("wait_oe", extOE, 1'b1);
                extOK   = ($urandom_range(0, 1) != 0) ? HOLD : READY;
                extData = $urandom;
                @(negedge clk);
                chk("wait_hold", memPcOK, HOLD);
            end
            chk("beat_addr", extAddr, {tag, bb, 2'b00});
            chk("beat_oe", extOE, 1'b1);
            if (b == fb) begin
                extOK = FAULT;
                @(negedge clk);
                extOK = READY;
                chk("flt_ok", memPcOK, FAULT);
                chk("flt_oe", extOE, 1'b0);
                chk("flt_addr", extAddr, 32'h0);
                return;
            end
            extOK   = OK;
            extData = word({tag, bb, 2'b00});
            @(negedge clk);
        end
        extOK = READY;
        chk("fill_ok", memPcOK, OK);
        chk("fill_oe", extOE, 1'b0);
        chk("fill_data", memPcData, line_of(tag));
        mvalid = 1'b1;
        mtag   = tag;
    endtask

    task automatic release_req();
        @(negedge clk);
        memPcOE = 1'b0;
        extOK   = READY;
        @(negedge clk);
        chk("rel_ok", memPcOK, READY);
        chk("rel_oe", extOE, 1'b0);
        chk("rel_addr", extAddr, 32'h0);
    endtask

    initial begin
        logic [31:0] pool [3];
        logic [31:0] a;
        logic [27:0] t;
        int          fb;

        rst_n      = 1'b0;
        memPcAddr  = '0;
        memPcOE    = 1'b0;
        extData    = '0;
        extOK      = READY;
        memPcAddr2 = '0;
        memPcOE2   = 1'b0;
        extData2   = '0;
        extOK2     = READY;
        mvalid     = 1'b0;
        mtag       = '0;
        mem[32'h1230] = 32'h11111111;
        mem[32'h1234] = 32'h22222222;
        mem[32'h1238] = 32'h33333333;
        mem[32'h123C] = 32'h44444444;

        repeat (2) @(negedge clk);
        chk("rst_ok", memPcOK, READY);
        chk("rst_data", memPcData, 128'h0);
        chk("rst_addr", extAddr, 32'h0);
        chk("rst_oe", extOE, 1'b0);
        rst_n = 1'b1;

        // Cold miss with a zero-wait bus, then a hit after release.
        request(32'h0000_1230, -1, -1, 0, 0);
        chk("cold_data", memPcData,
            128'h44444444_33333333_22222222_11111111);
        release_req();
        request(32'h0000_123A, -1, -1, 0, 0);
        chk("hit_lit", memPcData,
            128'h44444444_33333333_22222222_11111111);
        release_req();

        // Three wait cycles on beat 1.
        request(32'h0000_2340, -1, 1, 3, 0);
        release_req();

        // Bus fault on beat 2, then the same line must miss.
        request(32'h0000_3450, 2, -1, 0, 1);
        release_req();
        request(32'h0000_3450, -1, -1, 0, 1);
        release_req();

        // Back-to-back lines without releasing memPcOE.
        request(32'h0000_1230, -1, -1, 0, 0);
        request(32'h0000_4560, -1, -1, 0, 0);
        release_req();
        request(32'h0000_1230, -1, -1, 0, 1);
        release_req();

        // Randomized mix over a small tag pool (tag 0 included).
        pool[0] = 32'h0;
        pool[1] = {$urandom_range(1, 32'h0FFF_FFFF), 4'h0};
        pool[2] = {$urandom_range(1, 32'h0FFF_FFFF), 4'h0};
        for (int i = 0; i < 30; i++) begin
            a  = pool[$urandom_range(0, 2)] | 32'($urandom_range(0, 15));
            fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            request(a, fb, -1, 0, 2);
            if (fb >= 0 || $urandom_range(0, 1) != 0) release_req();
        end
        release_req();

        // Timeout with TIMEOUT_W=2: fault after three wait cycles.
        @(negedge clk);
        memPcOE2   = 1'b1;
        memPcAddr2 = 32'h0000_7770;
        extOK2     = HOLD;
        @(negedge clk);
        chk("to_hold0", memPcOK2, HOLD);
        @(negedge clk);
        chk("to_hold1", memPcOK2, HOLD);
        @(negedge clk);
        chk("to_hold2", memPcOK2, HOLD);
        chk("to_oe2", extOE2, 1'b1);
        @(negedge clk);
        chk("to_fault", memPcOK2, FAULT);
        chk("to_oe", extOE2, 1'b0);
        @(negedge clk);
        chk("to_stay", memPcOK2, FAULT);
        memPcOE2 = 1'b0;
        @(negedge clk);
        chk("to_ready", memPcOK2, READY);
        memPcOE2 = 1'b1;
        @(negedge clk);
        chk("to_remiss", memPcOK2, HOLD);
        memPcOE2 = 1'b0;
        extOK2   = READY;

        // Reset asserted after beat 1 of a fill.
        t = 28'h0ABCDEF;
        a = {t, 4'h0};
        @(negedge clk);
        memPcOE   = 1'b1;
        memPcAddr = a;
        extOK     = READY;
        @(negedge clk);
        chk("rm_hold", memPcOK, HOLD);
        extOK   = OK;
        extData = word({t, 4'h0});
        @(negedge clk);
        extData = word({t, 4'h4});
        @(negedge clk);
        chk("rm_beat2_addr", extAddr, {t, 4'h8});
        extOK   = READY;
        memPcOE = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_ok", memPcOK, READY);
        chk("rm_data", memPcData, 128'h0);
        chk("rm_addr", extAddr, 32'h0);
        chk("rm_oe", extOE, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mvalid = 1'b0;
        request(a, -1, -1, 0, 1);
        release_req();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icline_resp.md
# icline_resp

Memory-side responder for the I-cache line-fetch port. Accepts 16-byte line requests on the memPc interface (address, output-enable, 2-bit status), fills each line from a 32-bit word bus as four sequential beats, and returns the full 128-bit line with an OK status. It keeps the last filled line in a one-entry buffer, so a repeated request for the same line completes without a bus access. It sits between the instruction-cache tiles and the external memory arbiter.

## Interface
Parameters
- TIMEOUT_W, 8: width of the per-beat wait counter. A beat that is not completed within 2^TIMEOUT_W−1 cycles faults.

Status encoding, used on both memPcOK and extOK
- READY = 2'b00
- OK = 2'b01
- HOLD = 2'b10
- FAULT = 2'b11

Ports
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- memPcAddr  in  32  requested line address; [31:4] is the line tag, [3:0] is ignored.
- memPcOE  in  1  request valid; the requester holds it and memPcAddr stable until it sees OK or FAULT.
- memPcData  out  128  line buffer; beat i occupies [32i+31:32i].
- memPcOK  out  2  response status.
- extAddr  out  32  word address {tag, beat[1:0], 2'b00}; 0 when idle.
- extOE  out  1  word-read request.
- extData  in  32  read word; valid when extOK==OK.
- extOK  in  2  word-bus status, sampled at each edge while extOE=1.

## Operation
- State: lineBuf[127:0], lineTag[27:0], lineValid, beat[1:0], waitCnt, and FSM state ∈ {IDLE, FILL, DONE, FLT}.
- All outputs are registered.
- IDLE: memPcOK=READY, extOE=0.
  - memPcOE=1 with lineValid and memPcAddr[31:4]==lineTag → DONE.
  - memPcOE=1 otherwise → FILL with beat=0 and waitCnt=0; latch the tag into reqTag and clear lineValid.
- FILL: memPcOK=HOLD, extOE=1, extAddr={reqTag, beat, 2'b00}.
  - extOK=OK → write extData into lineBuf[beat], set waitCnt=0, increment beat.
  - On beat 3 with extOK=OK: set lineTag=reqTag and lineValid=1. Go to DONE if memPcOE=1, otherwise IDLE.
  - extOK=HOLD or READY → waitCnt++. When waitCnt reaches all-ones → FLT.
  - extOK=FAULT → FLT.
  - lineValid stays 0 on every path into FLT.
- DONE: memPcOK=OK, memPcData=lineBuf.
  - memPcOE=0 → IDLE.
  - memPcOE=1 with a different tag → FILL for that tag, treated as a new miss.
  - memPcOE=1 with the same tag → stay in DONE.
- FLT: memPcOK=FAULT and extOE=0 until memPcOE=0, then IDLE.
- memPcOE dropping mid-FILL does not abort the fill. The fill completes and the line is retained.
- memPcAddr is not re-sampled during FILL; reqTag governs the fill.

## Timing
- Reset values, asserted asynchronously: state=IDLE, memPcOK=READY, memPcData=0, extAddr=0, extOE=0, lineValid=0, beat=0, waitCnt=0.
- Hit: memPcOE sampled at edge N → memPcOK=OK after edge N. Latency is 1 cycle.
- Miss with a zero-wait word bus (extOK=OK on every beat): memPcOE sampled at edge N → HOLD after N; beats captured at N+1 through N+4; OK after edge N+4. Latency is 5 cycles.
- Each wait cycle on a beat adds one cycle.
- extAddr is stable for the whole of each beat and advances on the edge that captures the beat.
- The requester may sample memPcData in the same cycle that memPcOK=OK. memPcData does not change while in DONE.
- If reset is asserted mid-FILL, the partial line is discarded (lineValid=0) and extOE drops immediately.
- Tag 0x0000000 is a legal line; validity comes from lineValid alone.

## Test plan
- Cold miss, zero-wait: memPcOE=1, memPcAddr=0x00001230, extData=0x11111111/0x22222222/0x33333333/0x44444444 → extAddr 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles; memPcOK=OK 5 cycles after the request; memPcData=0x44444444_33333333_22222222_11111111.
- Hit after release: drop memPcOE for one cycle, then re-request 0x0000123A → OK one cycle later, no extOE pulse, same data.
- Wait states and timeout: hold extOK=HOLD for 3 cycles on beat 1 → OK arrives 3 cycles late. With TIMEOUT_W=2 and extOK stuck at HOLD → FAULT after 3 wait cycles; memPcOK stays FAULT until memPcOE=0, then READY; a re-request for the same tag misses.
- Bus fault on beat 2 → memPcOK=FAULT, lineValid=0, extOE=0 on the next cycle.
- Back-to-back lines: while in DONE for tag 0x123, switch memPcAddr to 0x00004560 with memPcOE held → HOLD, then fill 0x4560–0x456C. A subsequent request for 0x1230 misses.
- Reset mid-FILL (after beat 1): all outputs return to reset values asynchronously; the next request for the same line performs a full 4-beat fill.
